tcam_rule_prog: RTL and testbench

Control-plane write sequencer for the data-plane TCAM: the writer side of the TCAM programming port. It accepts rule commands (write rule, delete entry, clear all) over a valid/ready handshake. It expands each command into the value-then-mask write pair the TCAM port expects, and keeps a shadow valid bitmap of programmed entries. It asserts lookup_hold while any entry is half-updated so the pipeline can stall key_valid.

---
 rtl/tcam_pkg.sv | 14 +
 rtl/tcam_rule_prog.sv | 106 ++++++++++
 tb/tb_tcam_rule_prog.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/tcam_pkg.sv
// tcam_pkg: shared defaults, op encodings and FSM states for the TCAM rule writer.
package tcam_pkg;
  localparam int DEF_KEY_W = 128;
  localparam int DEF_ENTRIES = 16;
  localparam int DEF_IDX_W = $clog2(DEF_ENTRIES);
  localparam logic [DEF_KEY_W-1:0] DEF_DEL_PATTERN = '1;
  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_DELETE = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_RSVD   = 2'b11
  } op_t;
  typedef enum logic [2:0] {IDLE, WR_VAL, WR_MSK, SETTLE, DONE} state_t;
endpackage

// File: rtl/tcam_rule_prog.sv
// tcam_rule_prog: expands rule commands into TCAM value/mask write pairs and
// keeps a shadow valid bitmap; every output is a flop fed from next-state logic.
module tcam_rule_prog
  import tcam_pkg::*;
#(
  parameter int KEY_W = DEF_KEY_W,
  parameter int ENTRIES = DEF_ENTRIES,
  parameter logic [KEY_W-1:0] DEL_PATTERN = {KEY_W{1'b1}},
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [IDX_W-1:0]   cmd_addr,
  input  logic [KEY_W-1:0]   cmd_value,
  input  logic [KEY_W-1:0]   cmd_mask,
  output logic               tcam_wr_en,
  output logic               tcam_wr_is_mask,
  output logic [IDX_W-1:0]   tcam_wr_addr,
  output logic [KEY_W-1:0]   tcam_wr_data,
  output logic               lookup_hold,
  output logic [ENTRIES-1:0] entry_valid,
  output logic               done,
  output logic               err
);
  state_t state, state_n;
  op_t op_q, op_e;
  logic [IDX_W-1:0] addr_q, addr_e, cnt, cnt_n, cnt_inc, addr_n;
  logic [KEY_W-1:0] value_q, mask_q, value_e, mask_e, word_val, word_msk, data_n;
  logic [ENTRIES-1:0] ev_n;
  logic acc, wr_n, msk_n;
  always_comb begin
    acc = cmd_valid && cmd_ready;
    op_e = (state == IDLE) ? op_t'(cmd_op) : op_q;
    addr_e = (state == IDLE) ? cmd_addr : addr_q;
    value_e = (state == IDLE) ? cmd_value : value_q;
    mask_e = (state == IDLE) ? cmd_mask : mask_q;
    cnt_inc = cnt + 1'b1;
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: if (acc) begin
        state_n = (op_e == OP_RSVD) ? IDLE : WR_VAL;
        cnt_n = '0;
      end
      WR_VAL: state_n = WR_MSK;
      // a clear walks every entry; the counter wrapping back to 0 ends it
      WR_MSK: begin
        state_n = (op_e == OP_CLEAR && cnt_inc != '0) ? WR_VAL : SETTLE;
        cnt_n = (op_e == OP_CLEAR) ? cnt_inc : cnt;
      end
      SETTLE: state_n = DONE;
      default: state_n = IDLE;
    endcase
    wr_n = state_n == WR_VAL || state_n == WR_MSK;
    msk_n = state_n == WR_MSK;
    word_val = (op_e == OP_WRITE) ? (value_e & ~mask_e) : DEL_PATTERN;
    word_msk = (op_e == OP_WRITE) ? mask_e : '0;
    addr_n = !wr_n ? '0 : (op_e == OP_CLEAR) ? cnt_n : addr_e;
    data_n = !wr_n ? '0 : msk_n ? word_msk : word_val;
    ev_n = entry_valid;
    if (state == WR_MSK && state_n == SETTLE) begin
      if (op_e == OP_CLEAR) ev_n = '0;
      else ev_n[addr_e] = op_e == OP_WRITE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q <= OP_WRITE;
      addr_q <= '0;
      value_q <= '0;
      mask_q <= '0;
      cnt <= '0;
      cmd_ready <= 1'b0;
      tcam_wr_en <= 1'b0;
      tcam_wr_is_mask <= 1'b0;
      tcam_wr_addr <= '0;
      tcam_wr_data <= '0;
      lookup_hold <= 1'b0;
      entry_valid <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (acc) begin
        op_q <= op_e;
        addr_q <= cmd_addr;
        value_q <= cmd_value;
        mask_q <= cmd_mask;
      end
      cmd_ready <= state_n == IDLE;
      tcam_wr_en <= wr_n;
      tcam_wr_is_mask <= msk_n;
      tcam_wr_addr <= addr_n;
      tcam_wr_data <= data_n;
      lookup_hold <= wr_n || state_n == SETTLE;
      entry_valid <= ev_n;
      done <= state_n == DONE;
      err <= state == IDLE && acc && op_e == OP_RSVD;
    end
  end
endmodule

// File: tb/tb_tcam_rule_prog.sv
// tb_tcam_rule_prog: directed checks of write/delete/clear/reserved sequencing,
// back-to-back issue and asynchronous reset in the middle of a clear.
module tb_tcam_rule_prog;
  import tcam_pkg::*;
  localparam int KW = 128;
  localparam int N = 16;
  localparam int IW = 4;
  localparam logic [KW-1:0] ONES = '1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [IW-1:0] cmd_addr = '0;
  logic [KW-1:0] cmd_value = '0;
  logic [KW-1:0] cmd_mask = '0;
  logic tcam_wr_en, tcam_wr_is_mask, lookup_hold, done, err;
  logic [IW-1:0] tcam_wr_addr;
  logic [KW-1:0] tcam_wr_data;
  logic [N-1:0] entry_valid;
  logic [KW-1:0] tv [N];
  logic [KW-1:0] tm [N];
  int wr_cnt = 0;
  int checks = 0;
  int errors = 0;
  int hold_cnt, wr_before, wr_snap;

  tcam_rule_prog dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_value(cmd_value), .cmd_mask(cmd_mask),
    .tcam_wr_en(tcam_wr_en), .tcam_wr_is_mask(tcam_wr_is_mask),
    .tcam_wr_addr(tcam_wr_addr), .tcam_wr_data(tcam_wr_data),
    .lookup_hold(lookup_hold), .entry_valid(entry_valid),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // behavioural TCAM fed from the write port
  always @(posedge clk) if (tcam_wr_en) begin
    if (tcam_wr_is_mask) tm[tcam_wr_addr] <= tcam_wr_data;
    else tv[tcam_wr_addr] <= tcam_wr_data;
    wr_cnt <= wr_cnt + 1;
  end

  function automatic logic hit(input logic [KW-1:0] key, input int i);
    return entry_valid[i] && (((key ^ tv[i]) & ~tm[i]) == '0);
  endfunction

  task automatic chk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [IW-1:0] a,
                       input logic [KW-1:0] v, input logic [KW-1:0] m);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = a;
    cmd_value = v;
    cmd_mask = m;
    tick;
    cmd_valid = 1'b0;
  endtask

  initial begin
    repeat (3) tick;
    chk("rst_outputs", {cmd_ready, tcam_wr_en, tcam_wr_is_mask, lookup_hold, done, err,
                        tcam_wr_addr, tcam_wr_data != '0, entry_valid}, '0);
    rst_n = 1'b1;
    tick;
    chk("ready_after_rst", cmd_ready, 1);
    // write rule addr 3
    issue(OP_WRITE, 4'd3, 'hAB, 'h0F);
    chk("wr_t1_en", tcam_wr_en, 1);
    chk("wr_t1_msk", tcam_wr_is_mask, 0);
    chk("wr_t1_addr", tcam_wr_addr, 3);
    chk("wr_t1_data", tcam_wr_data, 'hA0);
    chk("wr_t1_hold", lookup_hold, 1);
    chk("wr_t1_ready", cmd_ready, 0);
    tick;
    chk("wr_t2_msk", tcam_wr_is_mask, 1);
    chk("wr_t2_data", tcam_wr_data, 'h0F);
    tick;
    chk("wr_t3_en", tcam_wr_en, 0);
    chk("wr_t3_data", tcam_wr_data, 0);
    chk("wr_t3_hold", lookup_hold, 1);
    chk("wr_t3_valid", entry_valid, 16'h0008);
    chk("wr_t3_done", done, 0);
    tick;
    chk("wr_t4_done", done, 1);
    chk("wr_t4_hold", lookup_hold, 0);
    chk("hit_a7", hit('hA7, 3), 1);
    chk("miss_b7", hit('hB7, 3), 0);
    tick;
    chk("wr_t5_ready", cmd_ready, 1);
    chk("wr_t5_done", done, 0);
    // delete addr 3
    issue(OP_DELETE, 4'd3, 'h1234, 'h0);
    chk("del_t1_data", tcam_wr_data, ONES);
    chk("del_t1_msk", tcam_wr_is_mask, 0);
    tick;
    chk("del_t2_data", tcam_wr_data, 0);
    chk("del_t2_msk", tcam_wr_is_mask, 1);
    tick;
    chk("del_t3_valid", entry_valid, 0);
    tick;
    chk("del_t4_done", done, 1);
    chk("del_miss_a7", hit('hA7, 3), 0);
    tick;
    // populate entry 5 so the clear has something to remove
    issue(OP_WRITE, 4'd5, 'h55, 'h0);
    repeat (3) tick;
    chk("pre_clr_valid", entry_valid, 16'h0020);
    tick;
    // clear all
    wr_before = wr_cnt;
    hold_cnt = 0;
    issue(OP_CLEAR, 4'd9, 'h0, 'h0);
    for (int k = 0; k < 2 * N; k++) begin
      chk($sformatf("clr_en_%0d", k), tcam_wr_en, 1);
      chk($sformatf("clr_addr_%0d", k), tcam_wr_addr, k / 2);
      chk($sformatf("clr_msk_%0d", k), tcam_wr_is_mask, k % 2);
      chk($sformatf("clr_data_%0d", k), tcam_wr_data, (k % 2) ? '0 : ONES);
      if (lookup_hold) hold_cnt++;
      tick;
    end
    if (lookup_hold) hold_cnt++;
    chk("clr_settle_en", tcam_wr_en, 0);
    chk("clr_settle_valid", entry_valid, 0);
    chk("clr_settle_done", done, 0);
    tick;
    chk("clr_done", done, 1);
    chk("clr_done_hold", lookup_hold, 0);
    chk("clr_hold_cycles", hold_cnt, 33);
    chk("clr_wr_count", wr_cnt - wr_before, 32);
    tick;
    chk("clr_ready", cmd_ready, 1);
    // reserved op
    issue(OP_RSVD, 4'd2, 'h77, 'h0);
    chk("rsvd_err", err, 1);
    chk("rsvd_en", tcam_wr_en, 0);
    chk("rsvd_hold", lookup_hold, 0);
    chk("rsvd_ready", cmd_ready, 1);
    chk("rsvd_done", done, 0);
    tick;
    chk("rsvd_err_pulse", err, 0);
    chk("rsvd_en2", tcam_wr_en, 0);
    // back-to-back with cmd_valid held
    cmd_valid = 1'b1;
    cmd_op = OP_WRITE;
    cmd_addr = 4'd1;
    cmd_value = 'h11;
    cmd_mask = 'h0;
    tick;
    chk("b2b_first_addr", tcam_wr_addr, 1);
    chk("b2b_first_data", tcam_wr_data, 'h11);
    cmd_addr = 4'd2;
    cmd_value = 'h22;
    repeat (3) tick;
    chk("b2b_done1", done, 1);
    chk("b2b_t4_en", tcam_wr_en, 0);
    chk("b2b_t4_ready", cmd_ready, 0);
    tick;
    chk("b2b_t5_ready", cmd_ready, 1);
    chk("b2b_t5_en", tcam_wr_en, 0);
    tick;
    cmd_valid = 1'b0;
    chk("b2b_second_en", tcam_wr_en, 1);
    chk("b2b_second_addr", tcam_wr_addr, 2);
    chk("b2b_second_data", tcam_wr_data, 'h22);
    repeat (3) tick;
    chk("b2b_done2", done, 1);
    chk("b2b_valid", entry_valid, 16'h0006);
    tick;
    // reset during WR_MSK of a clear
    issue(OP_CLEAR, 4'd0, 'h0, 'h0);
    tick;
    chk("rstmid_in_msk", tcam_wr_is_mask, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_async", {cmd_ready, tcam_wr_en, tcam_wr_is_mask, lookup_hold, done, err,
                         tcam_wr_addr, tcam_wr_data != '0, entry_valid}, '0);
    wr_snap = wr_cnt;
    repeat (3) tick;
    chk("rstmid_held_en", tcam_wr_en, 0);
    rst_n = 1'b1;
    tick;
    chk("rstmid_ready", cmd_ready, 1);
    chk("rstmid_en", tcam_wr_en, 0);
    repeat (3) tick;
    chk("rstmid_no_writes", wr_cnt - wr_snap, 0);
    chk("rstmid_valid", entry_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
